// File: rtl/lc3_pkg.sv
// lc3_pkg: shared LC-3 register-file constants and the arbiter state type.
package lc3_pkg;

    localparam int REG_CNT = 8;
    localparam int REG_AW  = 3;

    typedef enum logic [1:0] {
        RFA_CLEAR,
        RFA_IDLE,
        RFA_ACC,
        RFA_ACK
    } rfa_state_t;

endpackage

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares the register-file write and SR1 ports between the CPU and a debug host,
// zeroing R0-R7 after reset and granting debug accesses only at fetch boundaries.
module regfile_arbiter
    import lc3_pkg::*;
#(
    parameter int DW             = 16,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ld_reg,
    input  logic [REG_AW-1:0] cpu_dr,
    input  logic [DW-1:0]     cpu_bus,
    input  logic [REG_AW-1:0] cpu_sr1,
    input  logic [REG_AW-1:0] cpu_sr2,
    input  logic              cpu_fetch,
    output logic              cpu_hold,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [REG_AW-1:0] dbg_addr,
    input  logic [DW-1:0]     dbg_wdata,
    output logic              dbg_ack,
    output logic [DW-1:0]     dbg_rdata,
    output logic              rf_ld,
    output logic [REG_AW-1:0] rf_dr,
    output logic [DW-1:0]     rf_bus,
    output logic [REG_AW-1:0] rf_sr1,
    output logic [REG_AW-1:0] rf_sr2,
    input  logic [DW-1:0]     rf_sr1_out,
    output logic              err_ld_drop
);

    localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(REG_CNT - 1);

    rfa_state_t        state_q;
    logic [REG_AW-1:0] clr_idx_q;
    logic [REG_AW-1:0] addr_q;
    logic              we_q;
    logic [DW-1:0]     wdata_q;
    logic [DW-1:0]     rdata_q;
    logic              ack_q;
    logic              err_q;
    logic              grant;
    logic              in_clear;
    logic              acc_wr;
    logic              acc_rd;

    assign grant    = (state_q == RFA_IDLE) & dbg_req & cpu_fetch;
    assign in_clear = state_q == RFA_CLEAR;
    assign acc_wr   = (state_q == RFA_ACC) & we_q;
    assign acc_rd   = (state_q == RFA_ACC) & ~we_q;

    // The CPU is stalled in the grant cycle itself, so any CPU write then is dropped.
    assign cpu_hold = (state_q != RFA_IDLE) | grant;

    always_comb begin
        rf_ld  = in_clear ? 1'b1 : acc_wr ? 1'b1 : (state_q == RFA_IDLE) ? (cpu_ld_reg & ~grant) : 1'b0;
        rf_dr  = in_clear ? clr_idx_q : acc_wr ? addr_q : cpu_dr;
        rf_bus = in_clear ? '0 : acc_wr ? wdata_q : cpu_bus;
        rf_sr1 = acc_rd ? addr_q : cpu_sr1;
        rf_sr2 = cpu_sr2;
    end

    assign dbg_ack     = ack_q;
    assign dbg_rdata   = rdata_q;
    assign err_ld_drop = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR_ON_RESET ? RFA_CLEAR : RFA_IDLE;
            clr_idx_q <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= err_q | (cpu_ld_reg & cpu_hold);
            case (state_q)
                RFA_CLEAR: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == LAST_IDX) state_q <= RFA_IDLE;
                end
                RFA_IDLE: begin
                    if (grant) begin
                        we_q    <= dbg_we;
                        addr_q  <= dbg_addr;
                        wdata_q <= dbg_wdata;
                        state_q <= RFA_ACC;
                    end
                end
                RFA_ACC: begin
                    if (!we_q) rdata_q <= rf_sr1_out;
                    ack_q   <= 1'b1;
                    state_q <= RFA_ACK;
                end
                default: state_q <= RFA_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed vectors and hand-written sequences against a behavioural 8x16 register file.
module tb_regfile_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ld_reg;
    logic [2:0]  cpu_dr;
    logic [15:0] cpu_bus;
    logic [2:0]  cpu_sr1;
    logic [2:0]  cpu_sr2;
    logic        cpu_fetch;
    logic        cpu_hold;
    logic        dbg_req;
    logic        dbg_we;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_wdata;
    logic        dbg_ack;
    logic [15:0] dbg_rdata;
    logic        rf_ld;
    logic [2:0]  rf_dr;
    logic [15:0] rf_bus;
    logic [2:0]  rf_sr1;
    logic [2:0]  rf_sr2;
    logic [15:0] rf_sr1_out;
    logic        err_ld_drop;

    logic [15:0] regs [8];
    logic        pre;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    regfile_arbiter #(.DW(16), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst),
        .cpu_ld_reg(cpu_ld_reg), .cpu_dr(cpu_dr), .cpu_bus(cpu_bus),
        .cpu_sr1(cpu_sr1), .cpu_sr2(cpu_sr2), .cpu_fetch(cpu_fetch), .cpu_hold(cpu_hold),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .rf_ld(rf_ld), .rf_dr(rf_dr), .rf_bus(rf_bus), .rf_sr1(rf_sr1), .rf_sr2(rf_sr2),
        .rf_sr1_out(rf_sr1_out), .err_ld_drop(err_ld_drop)
    );

    // Register file model; pre fills every register with 0xFFFF so the clear sequence is observable.
    always @(posedge clk) begin
        if (pre) begin
            for (int k = 0; k < 8; k++) regs[k] <= 16'hFFFF;
        end else if (rf_ld) begin
            regs[rf_dr] <= rf_bus;
        end
    end
    assign rf_sr1_out = regs[rf_sr1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    typedef struct {
        logic        ld;
        logic [2:0]  dr;
        logic [15:0] bus;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic        req;
        logic        fetch;
        logic        exp_ld;
        logic        exp_hold;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{1'b1, 3'd3, 16'h1234, 3'd0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[1] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234};
        vecs[2] = '{1'b1, 3'd2, 16'h0A0A, 3'd3, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234};
        vecs[3] = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0A0A};
        vecs[4] = '{1'b1, 3'd7, 16'hFFFF, 3'd7, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
        vecs[5] = '{1'b0, 3'd0, 16'h0000, 3'd7, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF};

        rst = 1'b1; pre = 1'b1;
        cpu_ld_reg = 1'b0; cpu_dr = '0; cpu_bus = '0; cpu_sr1 = '0; cpu_sr2 = '0; cpu_fetch = 1'b0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        cyc(); cyc();
        #1;
        chk("rst_ack", dbg_ack, 0);
        chk("rst_rdata", dbg_rdata, 0);
        chk("rst_err", err_ld_drop, 0);
        chk("rst_hold", cpu_hold, 1);

        // Clear sequence: cycles 1..8 write R0..R7 with zero.
        cyc();
        rst = 1'b0; pre = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("clr_ld", rf_ld, 1);
            chk("clr_dr", rf_dr, i);
            chk("clr_bus", rf_bus, 0);
            chk("clr_hold", cpu_hold, 1);
            cyc();
        end
        #1;
        chk("clr_hold_c9", cpu_hold, 0);
        for (int i = 0; i < 8; i++) chk("clr_zero", regs[i], 0);

        // Pass-through vectors in IDLE, including requests without a fetch boundary.
        for (int i = 0; i < 6; i++) begin
            cyc();
            cpu_ld_reg = vecs[i].ld; cpu_dr = vecs[i].dr; cpu_bus = vecs[i].bus;
            cpu_sr1 = vecs[i].sr1; cpu_sr2 = vecs[i].sr2;
            dbg_req = vecs[i].req; cpu_fetch = vecs[i].fetch;
            #1;
            chk("pt_ld", rf_ld, vecs[i].exp_ld);
            chk("pt_dr", rf_dr, vecs[i].dr);
            chk("pt_bus", rf_bus, vecs[i].bus);
            chk("pt_sr1", rf_sr1, vecs[i].sr1);
            chk("pt_sr2", rf_sr2, vecs[i].sr2);
            chk("pt_hold", cpu_hold, vecs[i].exp_hold);
            chk("pt_sr1_out", rf_sr1_out, vecs[i].exp_out);
        end
        cyc();
        cpu_ld_reg = 1'b0; dbg_req = 1'b0; cpu_fetch = 1'b0;

        // Debug write R5 = 0xBEEF.
        cyc();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 3'd5; dbg_wdata = 16'hBEEF; cpu_fetch = 1'b1; cpu_sr1 = 3'd5;
        #1;
        chk("wr_g_hold", cpu_hold, 1);
        chk("wr_g_ld", rf_ld, 0);
        chk("wr_g_ack", dbg_ack, 0);
        cyc();
        dbg_req = 1'b0; cpu_fetch = 1'b0; dbg_wdata = 16'h0000; dbg_addr = 3'd0;
        #1;
        chk("wr_acc_hold", cpu_hold, 1);
        chk("wr_acc_ld", rf_ld, 1);
        chk("wr_acc_dr", rf_dr, 5);
        chk("wr_acc_bus", rf_bus, 16'hBEEF);
        chk("wr_acc_ack", dbg_ack, 0);
        cyc();
        #1;
        chk("wr_ack", dbg_ack, 1);
        chk("wr_ack_hold", cpu_hold, 1);
        chk("wr_ack_ld", rf_ld, 0);
        chk("wr_visible", rf_sr1_out, 16'hBEEF);
        cyc();
        #1;
        chk("wr_done_hold", cpu_hold, 0);
        chk("wr_done_ack", dbg_ack, 0);

        // Debug read of R2 (0x0A0A) while the CPU selects R6.
        cyc();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 3'd2; cpu_fetch = 1'b1; cpu_sr1 = 3'd6;
        #1;
        chk("rd_g_hold", cpu_hold, 1);
        chk("rd_g_sr1", rf_sr1, 6);
        cyc();
        dbg_req = 1'b0; cpu_fetch = 1'b0;
        #1;
        chk("rd_acc_sr1", rf_sr1, 2);
        chk("rd_acc_ld", rf_ld, 0);
        cyc();
        #1;
        chk("rd_ack", dbg_ack, 1);
        chk("rd_data", dbg_rdata, 16'h0A0A);
        chk("rd_ack_sr1", rf_sr1, 6);
        cyc();
        #1;
        chk("rd_hold_rel", cpu_hold, 0);
        chk("rd_data_held", dbg_rdata, 16'h0A0A);

        // Starvation: request held without a fetch boundary never stalls the CPU.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 3'd5;
        for (int i = 0; i < 20; i++) begin
            cyc();
            #1;
            chk("starve_hold", cpu_hold, 0);
            chk("starve_ack", dbg_ack, 0);
        end
        cyc();
        cpu_fetch = 1'b1;
        cyc();
        dbg_req = 1'b0; cpu_fetch = 1'b0;
        cpu_ld_reg = 1'b1; cpu_dr = 3'd1; cpu_bus = 16'h5555;
        #1;
        chk("viol_acc_ld", rf_ld, 0);
        cyc();
        cpu_ld_reg = 1'b0;
        #1;
        chk("viol_ack", dbg_ack, 1);
        chk("viol_rdata", dbg_rdata, 16'hBEEF);
        chk("viol_err", err_ld_drop, 1);
        chk("viol_r1", regs[1], 0);
        for (int i = 0; i < 4; i++) cyc();
        #1;
        chk("viol_err_sticky", err_ld_drop, 1);

        // Reset during the ACC cycle of a read.
        cyc();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 3'd3; cpu_fetch = 1'b1;
        cyc();
        dbg_req = 1'b0; cpu_fetch = 1'b0; rst = 1'b1;
        #1;
        chk("abort_acc_sr1", rf_sr1, 3);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("abort_ack", dbg_ack, 0);
            chk("abort_dr", rf_dr, i);
            chk("abort_ld", rf_ld, 1);
            if (i == 0) begin
                chk("abort_rdata", dbg_rdata, 0);
                chk("abort_err", err_ld_drop, 0);
            end
            cyc();
        end
        #1;
        chk("abort_idle", cpu_hold, 0);
        chk("abort_r3", regs[3], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Owns the write port and SR1 read port of the LC-3 8×16 register file and shares them between the CPU datapath and a debug host (UART monitor). After reset it zeroes R0–R7 with one write per cycle, then passes CPU traffic through untouched. It grants single-register debug reads and writes only at instruction-fetch boundaries, stalling the CPU FSM with `cpu_hold` while it does so. It sits between the control FSM/datapath and the register file.

## Interface
- `DW`, 16: data width.
- `CLEAR_ON_RESET`, 1: 1 runs the 8-cycle zeroing sequence after reset; 0 goes straight to IDLE.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cpu_ld_reg`  in  1  CPU write strobe.
- `cpu_dr`  in  3  CPU destination register.
- `cpu_bus`  in  DW  CPU write data.
- `cpu_sr1`, `cpu_sr2`  in  3  CPU source selects.
- `cpu_fetch`  in  1  CPU FSM is in a fetch state; no register-file access this cycle or the next.
- `cpu_hold`  out  1  CPU FSM must not advance.
- `dbg_req`  in  1  debug access request, level.
- `dbg_we`  in  1  1 = write, 0 = read; sampled at grant.
- `dbg_addr`  in  3  register index; sampled at grant.
- `dbg_wdata`  in  DW  write data; sampled at grant.
- `dbg_ack`  out  1  one-cycle completion pulse.
- `dbg_rdata`  out  DW  read result, valid while `dbg_ack`=1 and held until the next read.
- `rf_ld`  out  1  to register file `LD_REG`.
- `rf_dr`  out  3  to register file `DR`.
- `rf_bus`  out  DW  to register file `BUS`.
- `rf_sr1`, `rf_sr2`  out  3  to register file `SR1` and `SR2`.
- `rf_sr1_out`  in  DW  from register file `SR1_OUT`.
- `err_ld_drop`  out  1  sticky; a CPU write arrived while `cpu_hold` was high.

## Operation
- State machine: CLEAR, IDLE, ACC, ACK.
- CLEAR:
  - `clr_idx` counts 0..7.
  - Drives `rf_ld`=1, `rf_dr`=`clr_idx`, `rf_bus`=0.
  - Moves to IDLE after `clr_idx`=7.
- IDLE:
  - Passes the CPU through: `rf_ld`=`cpu_ld_reg`, `rf_dr`=`cpu_dr`, `rf_bus`=`cpu_bus`, `rf_sr1`=`cpu_sr1`.
  - Grant condition is `dbg_req & cpu_fetch`. On grant, latch `dbg_we`, `dbg_addr`, `dbg_wdata` and go to ACC.
- ACC:
  - Write: `rf_ld`=1, `rf_dr`=latched addr, `rf_bus`=latched data.
  - Read: `rf_ld`=0, `rf_sr1`=latched addr; `dbg_rdata` captures `rf_sr1_out` at the end of the cycle.
  - Always moves to ACK.
- ACK: `dbg_ack`=1, `rf_ld`=0, then return to IDLE.
- `rf_sr2`=`cpu_sr2` in every state.
- `cpu_hold` is combinational: 1 in CLEAR, ACC and ACK, and in IDLE when the grant condition is true. This stalls the CPU in the same cycle as the grant.
- `cpu_ld_reg`=1 in any cycle with `cpu_hold`=1:
  - the CPU write is dropped, not forwarded;
  - `err_ld_drop` is set and stays set until `rst`.
- `dbg_req` still high in the IDLE cycle after ACK counts as a new request. One access is performed per ack; the host drops `dbg_req` during the ack cycle to avoid a repeat.
- `dbg_req` without `cpu_fetch` waits indefinitely. The CPU always has priority.

## Timing
- Reset values:
  - state = CLEAR (IDLE if `CLEAR_ON_RESET`=0), `clr_idx`=0.
  - `dbg_ack`=0, `dbg_rdata`=0, `err_ld_drop`=0.
  - `cpu_hold`=1 with CLEAR, 0 without.
- Clear sequence:
  - Writes R0..R7 in cycles 1..8 after `rst` falls.
  - First IDLE (CPU free) is cycle 9.
- Debug latency: grant cycle G (IDLE), access G+1 (ACC), `dbg_ack` G+2. `cpu_hold` is high for G..G+2, 3 cycles total.
- Written value is visible on `rf_sr1_out` from G+2.
- `rst` mid-CLEAR, ACC or ACK:
  - Abort immediately and restart CLEAR at index 0.
  - No `dbg_ack` is issued for the aborted access; a write in its ACC cycle may or may not land.
- Simultaneous `dbg_req` and `cpu_ld_reg` in IDLE with `cpu_fetch`=1: protocol violation by the CPU. The write is dropped and the error flag set, per the rule above.

## Structure
- Shared package `lc3_pkg`: state enum `rfa_state_t`, `REG_CNT`=8, `REG_AW`=3.
- No sub-module: a single FSM with a 3-bit counter and a capture register.

## Test plan
- Reset with `CLEAR_ON_RESET`=1 and registers preloaded 0xFFFF:
  - `rf_ld`=1 with `rf_dr`=0..7 and `rf_bus`=0 over 8 cycles;
  - `cpu_hold` high 8 cycles, low in cycle 9;
  - all registers read 0.
- CPU pass-through: `cpu_ld_reg`=1, `cpu_dr`=3, `cpu_bus`=0x1234 in IDLE → R3=0x1234 next cycle; `rf_sr1` follows `cpu_sr1`.
- Debug write: `dbg_req`=1, `dbg_we`=1, addr 5, data 0xBEEF, `cpu_fetch`=1 → hold for 3 cycles, `dbg_ack` at G+2, R5=0xBEEF.
- Debug read: R2=0x0A0A, read addr 2 → `dbg_rdata`=0x0A0A with `dbg_ack` at G+2; `rf_sr1`=2 during ACC, `cpu_sr1` restored after.
- Starvation and violation:
  - `dbg_req` held with `cpu_fetch`=0 for 20 cycles → no grant, no hold.
  - Then `cpu_ld_reg`=1 during ACC → R unchanged and `err_ld_drop`=1 until reset.
- `rst` asserted in ACC of a read → no `dbg_ack`; CLEAR restarts at R0; `dbg_rdata`=0.
